// File: rtl/pipelined_mem_responder_pkg.sv
// Shared definitions for the cache-fill memory responder and its users.
package mem_pkg;

    localparam int WORD_W      = 16;
    localparam int ADDR_W      = 16;
    // Words per cache block; a fill issues this many back-to-back reads.
    localparam int BLOCK_WORDS = 8;

    typedef struct packed {
        logic              enable;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data_in;
    } mem_req_t;

    // Byte address -> word index, wrapping silently into the array size.
    function automatic int word_index(input logic [ADDR_W-1:0] addr, input int depth);
        return int'(addr[ADDR_W-1:1]) % depth;
    endfunction

endpackage

// File: rtl/pipelined_mem_responder_delay_line.sv
// Fixed-depth shift register carrying {valid, data}; both clear on reset.
module mem_delay_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data
);

    logic             r_vld  [DEPTH];
    logic [WIDTH-1:0] r_data [DEPTH];

    // Shift one stage per clock; reset drops every in-flight entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_vld[i]  <= 1'b0;
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0]  <= i_vld;
            r_data[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    assign o_vld  = r_vld[DEPTH-1];
    assign o_data = r_data[DEPTH-1];

endmodule

// File: rtl/pipelined_mem_responder.sv
// Memory-side responder: immediate writes, fixed-latency pipelined reads.
module pipelined_mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY     = 4,
    parameter int DEPTH_WORDS = 32768
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic [3:0]        reads_in_flight
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    mem_req_t          w_req;
    logic [IDX_W-1:0]  w_idx;
    logic              w_rd_issue;
    logic              w_wr_issue;
    logic [WORD_W-1:0] w_launch_data;
    logic              w_dv;
    logic [WORD_W-1:0] w_dout;

    // Storage has no reset so contents survive rst_n pulses.
    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
    logic [3:0]        r_inflight;

    assign w_req      = '{enable: enable, wr: wr, addr: addr, data_in: data_in};
    assign w_idx      = IDX_W'(word_index(w_req.addr, DEPTH_WORDS));
    assign w_rd_issue = w_req.enable & ~w_req.wr;
    assign w_wr_issue = w_req.enable &  w_req.wr;

    // Read data is captured at issue; non-reads launch a zero bubble so
    // data_out is naturally 0 whenever data_valid is low.
    assign w_launch_data = w_rd_issue ? r_mem[w_idx] : '0;

    // Commit writes at the issuing edge; nothing is accepted while in reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_issue) begin
            r_mem[w_idx] <= w_req.data_in;
        end
    end

    mem_delay_line #(
        .WIDTH (WORD_W),
        .DEPTH (LATENCY)
    ) u_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_vld  (w_rd_issue),
        .i_data (w_launch_data),
        .o_vld  (w_dv),
        .o_data (w_dout)
    );

    // Track outstanding reads: up on issue, down as each response is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 4'd0;
        end else begin
            case ({w_rd_issue, w_dv})
                2'b10:   r_inflight <= r_inflight + 4'd1;
                2'b01:   r_inflight <= r_inflight - 4'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign data_out        = w_dout;
    assign data_valid      = w_dv;
    assign reads_in_flight = r_inflight;

endmodule

// File: tb/tb_pipelined_mem_responder.sv
// Self-checking bench for pipelined_mem_responder (LATENCY=4, 16-word array).
module tb_pipelined_mem_responder;
    import mem_pkg::*;

    localparam int LAT   = 4;
    localparam int DEPTH = 16;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        enable  = 1'b0;
    logic        wr      = 1'b0;
    logic [15:0] addr    = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        data_valid;
    logic [3:0]  reads_in_flight;

    always #5 clk = ~clk;

    pipelined_mem_responder #(
        .LATENCY     (LAT),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .wr              (wr),
        .addr            (addr),
        .data_in         (data_in),
        .data_out        (data_out),
        .data_valid      (data_valid),
        .reads_in_flight (reads_in_flight)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: word array plus a list of reads with the edge at
    // which each must be presented on the outputs.
    typedef struct {
        int          due;
        logic [15:0] data;
    } rsp_t;

    logic [15:0] m_mem [DEPTH];
    rsp_t        q [$];
    int          edge_cnt = 0;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end

    always @(posedge clk) begin
        int idx;
        edge_cnt++;
        if (rst_n) begin
            idx = int'(addr[15:1]) % DEPTH;
            if (enable && !wr) q.push_back('{due: edge_cnt + LAT - 1, data: m_mem[idx]});
            if (enable && wr)  m_mem[idx] = data_in;
        end
        while (q.size() > 0 && q[0].due < edge_cnt) void'(q.pop_front());
    end

    always @(negedge rst_n) q.delete();

    // Compare every cycle, mid-period.
    always @(negedge clk) begin
        logic        ev;
        logic [15:0] ed;
        int          cnt;
        ev  = 1'b0;
        ed  = '0;
        cnt = 0;
        foreach (q[i]) begin
            if (q[i].due == edge_cnt) begin
                ev = 1'b1;
                ed = q[i].data;
            end
            if (q[i].due >= edge_cnt) cnt++;
        end
        check("model_valid", {31'b0, data_valid}, {31'b0, ev});
        check("model_data", {16'b0, data_out}, {16'b0, ed});
        check("model_inflight", {28'b0, reads_in_flight}, cnt);
    end

    task automatic cyc(input logic e, input logic w, input logic [15:0] a, input logic [15:0] d);
        enable  = e;
        wr      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic rd(input logic [15:0] a);
        cyc(1'b1, 1'b0, a, 16'h0000);
    endtask

    task automatic wrt(input logic [15:0] a, input logic [15:0] d);
        cyc(1'b1, 1'b1, a, d);
    endtask

    task automatic expect_rsp(input string name, input logic [15:0] d);
        check({name, "_valid"}, {31'b0, data_valid}, 32'd1);
        check({name, "_data"}, {16'b0, data_out}, {16'b0, d});
    endtask

    initial begin
        #2;
        check("reset_valid", {31'b0, data_valid}, 32'd0);
        check("reset_data", {16'b0, data_out}, 32'h0);
        check("reset_inflight", {28'b0, reads_in_flight}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) wrt(16'(2 * i), 16'($urandom));

        // Read after write, single-cycle strobe
        wrt(16'h0040, 16'hBEEF);
        rd(16'h0040);
        check("raw_inflight", {28'b0, reads_in_flight}, 32'd1);
        idle(); idle(); idle();
        expect_rsp("raw", 16'hBEEF);
        idle();
        check("raw_strobe_len", {31'b0, data_valid}, 32'd0);

        // Cache-fill burst
        for (int i = 0; i < BLOCK_WORDS; i++) wrt(16'(16'h1000 + 2 * i), 16'(16'hA000 + i));
        for (int i = 0; i < BLOCK_WORDS + LAT - 1; i++) begin
            if (i < BLOCK_WORDS) rd(16'(16'h1000 + 2 * i));
            else idle();
            if (i >= LAT - 1) expect_rsp("burst", 16'(16'hA000 + i - (LAT - 1)));
            if (i == LAT - 1) check("burst_peak", {28'b0, reads_in_flight}, 32'd4);
        end
        idle();
        check("burst_drain_valid", {31'b0, data_valid}, 32'd0);
        check("burst_drain_inflight", {28'b0, reads_in_flight}, 32'd0);

        // Write after read issue does not disturb the in-flight read
        wrt(16'h0020, 16'h1111);
        rd(16'h0020);
        wrt(16'h0020, 16'h2222);
        idle(); idle();
        expect_rsp("war_old", 16'h1111);
        rd(16'h0020);
        idle(); idle(); idle();
        expect_rsp("war_new", 16'h2222);

        // Bubble preserved through the pipeline
        wrt(16'h0006, 16'h0BB0);
        rd(16'h0006);
        idle();
        rd(16'h0006);
        idle();
        expect_rsp("bubble_a", 16'h0BB0);
        idle();
        check("bubble_gap_valid", {31'b0, data_valid}, 32'd0);
        check("bubble_gap_data", {16'b0, data_out}, 32'h0);
        idle();
        expect_rsp("bubble_b", 16'h0BB0);

        // Reset mid-burst
        wrt(16'h0044, 16'h5A5A);
        rd(16'h000A); rd(16'h000C); rd(16'h000E);
        enable = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("midrst_valid", {31'b0, data_valid}, 32'd0);
        check("midrst_inflight", {28'b0, reads_in_flight}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 1; i++) begin
            idle();
            check("postrst_no_valid", {31'b0, data_valid}, 32'd0);
        end
        rd(16'h0044);
        idle(); idle(); idle();
        expect_rsp("postrst_array", 16'h5A5A);

        // Odd address and index wrap
        wrt(16'h0002, 16'h1234);
        rd(16'h0022);
        idle(); idle(); idle();
        expect_rsp("alias_wrap", 16'h1234);
        rd(16'h0041);
        idle(); idle(); idle();
        expect_rsp("alias_odd", 16'h2222);

        // Randomized traffic with occasional resets
        repeat (3000) begin
            if ($urandom_range(0, 199) == 0) begin
                enable = 1'b0;
                rst_n  = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
            end else begin
                cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    16'($urandom), 16'($urandom));
            end
        end
        repeat (LAT + 2) idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
